pipe_hazard_ctrl: RTL

- Central pipeline controller; drives the `stall`/`refresh` pair of every segment register (`if_id`, `id_ex`, `ex_mem`, `mem_wb`) plus `pc_stall`.
- Combines load-use, multi-cycle mult/div occupancy, IF/MEM bus waits, branch mispredict and commit-time exception/eret flush into one priority-resolved control vector.
- Owns the mult/div occupancy FSM, the stale-fetch cancel flag and a stall performance counter.

---
 rtl/pipe_hazard_ctrl_if.sv | 50 +++++
 rtl/pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard inputs and segment control outputs of the pipeline controller
interface pipe_hazard_ctrl_if;
  // Hazard sources presented by the pipeline
  logic        id_rs_ren;
  logic        id_rt_ren;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_load;
  logic        ex_regwen;
  logic [4:0]  ex_wreg;
  logic        ex_mult;
  logic        ex_div;
  logic        inst_req_wait;
  logic        data_req_wait;
  logic        ex_bp_miss;
  logic        wb_flush;
  // Segment controls and status returned by the controller
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_refresh;
  logic        id_ex_stall;
  logic        id_ex_refresh;
  logic        ex_mem_stall;
  logic        ex_mem_refresh;
  logic        mem_wb_stall;
  logic        mem_wb_refresh;
  logic        md_busy;
  logic        md_done;
  logic [31:0] perf_stall_cnt;

  // Pipeline side: reports hazards, obeys the control vector
  modport master (
    output id_rs_ren, id_rt_ren, id_rs, id_rt,
    output ex_load, ex_regwen, ex_wreg, ex_mult, ex_div,
    output inst_req_wait, data_req_wait, ex_bp_miss, wb_flush,
    input  pc_stall, if_id_stall, if_id_refresh, id_ex_stall, id_ex_refresh,
    input  ex_mem_stall, ex_mem_refresh, mem_wb_stall, mem_wb_refresh,
    input  md_busy, md_done, perf_stall_cnt
  );

  // Controller side
  modport slave (
    input  id_rs_ren, id_rt_ren, id_rs, id_rt,
    input  ex_load, ex_regwen, ex_wreg, ex_mult, ex_div,
    input  inst_req_wait, data_req_wait, ex_bp_miss, wb_flush,
    output pc_stall, if_id_stall, if_id_refresh, id_ex_stall, id_ex_refresh,
    output ex_mem_stall, ex_mem_refresh, mem_wb_stall, mem_wb_refresh,
    output md_busy, md_done, perf_stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - priority-resolved stall/refresh controller with mult/div occupancy FSM
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 2,
  parameter int DIV_CYCLES  = 33
) (
  input  logic              clk,
  input  logic              resetn,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  md_state_t        md_state;
  logic [CNT_W-1:0] md_cnt;
  logic             md_busy_q;
  logic             md_done_q;
  logic             cancel_q;
  logic [31:0]      perf_q;

  logic load_use;
  logic pc_hold;
  logic cancel_set;
  logic cancel_drop;
  logic pc_stall_c;
  logic if_id_stall_c, if_id_refresh_c;
  logic id_ex_stall_c, id_ex_refresh_c;
  logic ex_mem_stall_c, ex_mem_refresh_c;
  logic mem_wb_stall_c, mem_wb_refresh_c;

  assign load_use = hz.ex_load && hz.ex_regwen && (hz.ex_wreg != 5'd0) &&
                    ((hz.id_rs_ren && (hz.id_rs == hz.ex_wreg)) ||
                     (hz.id_rt_ren && (hz.id_rt == hz.ex_wreg)));

  // PC held by a hazard other than the fetch wait itself; the fetch wait must not
  // block a mispredict redirect from arming the cancel flag.
  assign pc_hold = !hz.wb_flush && (hz.data_req_wait || md_busy_q || load_use);

  assign cancel_set  = hz.inst_req_wait && (hz.wb_flush || (hz.ex_bp_miss && !pc_hold));
  // The stale fetch is dropped on the first cycle the fetch is complete and IF/ID is
  // free to take a bubble; if IF/ID is held, the drop waits so ID is not destroyed.
  assign cancel_drop = cancel_q && !hz.inst_req_wait && !pc_hold;

  // Resolve the hazards in priority order into one control vector
  always_comb begin
    pc_stall_c       = 1'b0;
    if_id_stall_c    = 1'b0;
    if_id_refresh_c  = 1'b0;
    id_ex_stall_c    = 1'b0;
    id_ex_refresh_c  = 1'b0;
    ex_mem_stall_c   = 1'b0;
    ex_mem_refresh_c = 1'b0;
    mem_wb_stall_c   = 1'b0;
    mem_wb_refresh_c = 1'b0;
    if (!resetn || hz.wb_flush) begin
      if_id_refresh_c  = 1'b1;
      id_ex_refresh_c  = 1'b1;
      ex_mem_refresh_c = 1'b1;
      mem_wb_refresh_c = 1'b1;
    end else if (hz.data_req_wait) begin
      pc_stall_c       = 1'b1;
      if_id_stall_c    = 1'b1;
      id_ex_stall_c    = 1'b1;
      ex_mem_stall_c   = 1'b1;
      mem_wb_refresh_c = 1'b1;
    end else if (md_busy_q) begin
      pc_stall_c       = 1'b1;
      if_id_stall_c    = 1'b1;
      id_ex_stall_c    = 1'b1;
      ex_mem_refresh_c = 1'b1;
    end else if (load_use) begin
      pc_stall_c      = 1'b1;
      if_id_stall_c   = 1'b1;
      id_ex_refresh_c = 1'b1;
    end else if (hz.inst_req_wait) begin
      pc_stall_c      = 1'b1;
      if_id_refresh_c = 1'b1;
    end else if (hz.ex_bp_miss) begin
      if_id_refresh_c = 1'b1;
    end
    if (cancel_drop) begin
      if_id_refresh_c = 1'b1;
    end
  end

  // Mult/div occupancy: IDLE -> BUSY (count down) -> DONE (held while MEM waits)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      md_state  <= MD_IDLE;
      md_cnt    <= '0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else if (hz.wb_flush) begin
      md_state  <= MD_IDLE;
      md_cnt    <= '0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      case (md_state)
        MD_IDLE: begin
          if (hz.ex_mult || hz.ex_div) begin
            md_state  <= MD_BUSY;
            md_busy_q <= 1'b1;
            md_cnt    <= hz.ex_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          end
        end
        MD_BUSY: begin
          if (md_cnt == '0) begin
            md_state  <= MD_DONE;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b1;
          end else begin
            md_cnt <= md_cnt - CNT_W'(1);
          end
        end
        MD_DONE: begin
          if (!hz.data_req_wait) begin
            md_state  <= MD_IDLE;
            md_done_q <= 1'b0;
          end
        end
        default: begin
          md_state  <= MD_IDLE;
          md_busy_q <= 1'b0;
          md_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Stale-fetch cancel flag; a new set outranks the clear in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cancel_q <= 1'b0;
    end else if (cancel_set) begin
      cancel_q <= 1'b1;
    end else if (cancel_drop) begin
      cancel_q <= 1'b0;
    end
  end

  // Count PC-stalled cycles, wrapping naturally at 32 bits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_q <= 32'd0;
    end else if (pc_stall_c) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign hz.pc_stall       = pc_stall_c;
  assign hz.if_id_stall    = if_id_stall_c;
  assign hz.if_id_refresh  = if_id_refresh_c;
  assign hz.id_ex_stall    = id_ex_stall_c;
  assign hz.id_ex_refresh  = id_ex_refresh_c;
  assign hz.ex_mem_stall   = ex_mem_stall_c;
  assign hz.ex_mem_refresh = ex_mem_refresh_c;
  assign hz.mem_wb_stall   = mem_wb_stall_c;
  assign hz.mem_wb_refresh = mem_wb_refresh_c;
  assign hz.md_busy        = md_busy_q;
  assign hz.md_done        = md_done_q;
  assign hz.perf_stall_cnt = perf_q;

endmodule
